bus_arbiter_n: RTL and testbench

Parametrised N-master bus arbiter for the system bus, successor to the two-master fixed-priority arbiter. Grants one master at a time, holds the grant while the master keeps its request, and waits for every slave to report ready before handing the bus to the next master. Adds round-robin fairness (compile-time option), a configurable hold limit with preemption, and a registered master-select output. Sits between the master request lines and the bus mux/decoder that consumes `msel`.

---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/bus_arb_picker.sv | 32 +++
 rtl/bus_arbiter_n.sv | 118 +++++++++++
 tb/tb_bus_arbiter_n.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared encodings and width helper for the N-master bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  // $clog2 clamped to at least one bit so degenerate counters stay legal
  function automatic int width_of(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arb_picker.sv
// Combinational masked priority picker: first eligible request at or after
// start, wrapping around.
module bus_arb_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [N-1:0] elig;
  assign elig = req & mask;

  // walk offsets high to low so the smallest offset from start wins
  always_comb begin
    logic [W-1:0] j;
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = N-1; k >= 0; k--) begin
      j = W'((int'(start) + k) % N);
      if (elig[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter with slave-ready handover, hold-limit preemption and
// registered master select. Define BUS_ARB_RR_EN for round-robin priority.
module bus_arbiter_n
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 3,
  parameter int MAX_HOLD    = 0,
  localparam int MSEL_W     = width_of(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] breq,
  input  logic [NUM_SLAVES-1:0]  sready,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [MSEL_W-1:0]      msel,
  output logic                   bus_busy
);

  localparam int HCW = width_of(MAX_HOLD + 1);

  arb_state_t        state, state_nxt;
  logic [MSEL_W-1:0] owner, owner_nxt;
  logic [HCW-1:0]    hold_cnt;
  logic              preempt, preempt_nxt;

  logic [NUM_MASTERS-1:0] own_oh, elig_mask;
  logic [MSEL_W-1:0]      pick_start, pick_idx;
  logic                   pick_vld, hold_hit, others_req, grant_entry;

  assign own_oh     = NUM_MASTERS'(1) << owner;
  assign others_req = |(breq & ~own_oh);
  // the Mth grant cycle is the one where the count still reads M-1
  assign hold_hit   = (MAX_HOLD > 0) && (int'(hold_cnt) >= MAX_HOLD - 1);
  // a preempted owner sits out the one arbitration that ends its WAIT
  assign elig_mask  = preempt ? ~own_oh : '1;

  bus_arb_picker #(.N(NUM_MASTERS), .W(MSEL_W)) u_pick (
    .req   (breq),
    .mask  (elig_mask),
    .start (pick_start),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    preempt_nxt = preempt;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_nxt = ST_GRANT;
          owner_nxt = pick_idx;
        end
      end
      ST_GRANT: begin
        if (!breq[owner]) begin
          state_nxt = ST_WAIT;
        end else if (hold_hit && others_req) begin
          state_nxt   = ST_WAIT;
          preempt_nxt = 1'b1;
        end
      end
      ST_WAIT: begin
        if (&sready) begin
          preempt_nxt = 1'b0;
          if (pick_vld) begin
            state_nxt = ST_GRANT;
            owner_nxt = pick_idx;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign grant_entry = (state_nxt == ST_GRANT) && (state != ST_GRANT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= '0;
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      preempt <= preempt_nxt;
      if (grant_entry)
        hold_cnt <= '0;
      else if (state == ST_GRANT && int'(hold_cnt) < MAX_HOLD)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

`ifdef BUS_ARB_RR_EN
  logic [MSEL_W-1:0] rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (grant_entry)
      rr_ptr <= (int'(owner_nxt) == NUM_MASTERS - 1) ? '0 : owner_nxt + 1'b1;
  end

  assign pick_start = rr_ptr;
`else
  assign pick_start = '0;
`endif

  assign bgrant   = (state == ST_GRANT) ? own_oh : '0;
  assign msel     = owner;
  assign bus_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Scoreboard bench for bus_arbiter_n (4 masters, 3 slaves, MAX_HOLD=4).
module tb_bus_arbiter_n;

  localparam int NM = 4;
  localparam int NS = 3;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NM-1:0] breq;
  logic [NS-1:0] sready;
  logic [NM-1:0] bgrant;
  logic [1:0]    msel;
  logic          bus_busy;

  bus_arbiter_n #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .MAX_HOLD(MH)) dut (
    .clk      (clk),
    .rst      (rst),
    .breq     (breq),
    .sready   (sready),
    .bgrant   (bgrant),
    .msel     (msel),
    .bus_busy (bus_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int grant;
    int sel;
    int busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // reference model state: 0 idle, 1 grant, 2 wait
  int m_state, m_owner, m_hold, m_ptr, m_pre;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_owner = 0; m_hold = 0; m_ptr = 0; m_pre = 0;
  endtask

  function automatic int model_pick(input logic [NM-1:0] b);
    int start;
`ifdef BUS_ARB_RR_EN
    start = m_ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < NM; k++) begin
      int j;
      j = (start + k) % NM;
      if (b[j] && !(m_pre != 0 && j == m_owner)) return j;
    end
    return -1;
  endfunction

  // advance the model by one edge and queue the outputs it predicts
  task automatic model_edge(input logic [NM-1:0] b, input logic [NS-1:0] s);
    int ns, no, np, w;
    exp_t e;
    ns = m_state; no = m_owner; np = m_pre;
    if (m_state == 0) begin
      w = model_pick(b);
      if (w >= 0) begin ns = 1; no = w; end
    end else if (m_state == 1) begin
      if (!b[m_owner]) ns = 2;
      else if (m_hold + 1 >= MH && (b & ~(4'b0001 << m_owner)) != 0) begin
        ns = 2; np = 1;
      end
    end else if (s == 3'b111) begin
      w = model_pick(b);
      np = 0;
      if (w >= 0) begin ns = 1; no = w; end
      else ns = 0;
    end
    if (ns == 1 && m_state != 1) begin
      m_hold = 0;
      m_ptr  = (no + 1) % NM;
    end else if (m_state == 1 && m_hold < MH) begin
      m_hold++;
    end
    m_state = ns; m_owner = no; m_pre = np;
    e.grant = (ns == 1) ? (1 << no) : 0;
    e.sel   = no;
    e.busy  = (ns != 0) ? 1 : 0;
    sb_q.push_back(e);
  endtask

  // called at a negedge: drive, clock once, compare at the following negedge
  task automatic step(input logic [NM-1:0] b, input logic [NS-1:0] s);
    exp_t e;
    breq = b; sready = s;
    model_edge(b, s);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    chk("sb_grant", int'(bgrant), e.grant);
    chk("sb_msel", int'(msel), e.sel);
    chk("sb_busy", int'(bus_busy), e.busy);
    chk("onehot0", int'($onehot0(bgrant)), 1);
  endtask

  int order[5];
  int exp_order[5];
  int hold_cycles;

  initial begin
    rst = 1'b1; breq = 4'b0100; sready = 3'b111;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_grant", int'(bgrant), 0);
    chk("rst_msel", int'(msel), 0);
    chk("rst_busy", int'(bus_busy), 0);
    rst = 1'b0;
    step(4'b0100, 3'b111);
    chk("first_grant", int'(bgrant), 4);
    chk("first_msel", int'(msel), 2);
    chk("first_busy", int'(bus_busy), 1);
    step(4'b0000, 3'b111);
    step(4'b0000, 3'b111);
    chk("back_idle", int'(bus_busy), 0);

    // slave-wait handover from master 1 to master 3
    step(4'b0010, 3'b111);
    chk("m1_grant", int'(bgrant), 2);
    step(4'b1010, 3'b111);
    for (int i = 0; i < 3; i++) begin
      step(4'b1000, 3'b101);
      chk("wait_nogrant", int'(bgrant), 0);
    end
    step(4'b1000, 3'b111);
    chk("handover_grant", int'(bgrant), 8);
    step(4'b0000, 3'b111);
    step(4'b0000, 3'b111);

    // fairness: everyone requests, owner drops for one cycle after 2 grants
    for (int g = 0; g < 5; g++) begin
      step(4'b1111, 3'b111);
      order[g] = int'(msel);
      step(4'b1111, 3'b111);
      step(4'b1111 & ~(4'b0001 << order[g]), 3'b111);
      chk("drop_nogrant", int'(bgrant), 0);
    end
`ifdef BUS_ARB_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    for (int g = 0; g < 5; g++) chk("grant_order", order[g], exp_order[g]);
    step(4'b0000, 3'b111);
    step(4'b0000, 3'b111);

    // preemption after MAX_HOLD cycles with master 2 waiting
    hold_cycles = 0;
    step(4'b0001, 3'b111);
    if (bgrant == 4'b0001) hold_cycles++;
    for (int i = 0; i < 4; i++) begin
      step(4'b0101, 3'b111);
      if (bgrant == 4'b0001) hold_cycles++;
    end
    chk("hold_cycles", hold_cycles, MH);
    chk("preempt_wait", int'(bgrant), 0);
    step(4'b0101, 3'b111);
    chk("preempt_winner", int'(bgrant), 4);
    step(4'b0000, 3'b111);
    step(4'b0000, 3'b111);

    // asynchronous reset between edges
    step(4'b0010, 3'b111);
    chk("pre_rst_grant", int'(bgrant), 2);
    #1 rst = 1'b1;
    #1;
    chk("async_grant", int'(bgrant), 0);
    chk("async_msel", int'(msel), 0);
    #1 rst = 1'b0;
    model_reset();
    step(4'b0010, 3'b111);
    chk("rearb_grant", int'(bgrant), 2);

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [NM-1:0] rb;
      logic [NS-1:0] rs;
      rb = NM'($urandom_range(0, 15));
      rs = ($urandom_range(0, 3) == 0) ? NS'($urandom_range(0, 7)) : 3'b111;
      step(rb, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no summary expected finish");
    $fatal(1);
  end

endmodule
